// File: rtl/chip_seq_pkg.sv
// =============================================================================
// Module   : chip_seq_pkg
// Purpose  : Shared types and helpers for the chip test sequencer.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package chip_seq_pkg;

    localparam int STATS_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        RELEASE = 3'd4,
        SHOW    = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        V_NONE    = 2'd0,
        V_PASS    = 2'd1,
        V_FAIL    = 2'd2,
        V_TIMEOUT = 2'd3
    } verdict_t;

    // A timeout overrides whatever stale result was captured earlier.
    function automatic verdict_t verdict_of(input logic res, input logic timed_out);
        if (timed_out) begin
            return V_TIMEOUT;
        end else if (res) begin
            return V_PASS;
        end
        return V_FAIL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// =============================================================================
// Module   : sync_edge_det
// Purpose  : Two-flop synchronizer followed by a rising-edge one-cycle pulse.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module sync_edge_det (
    input  logic Clk,
    input  logic Reset_n,
    input  logic din_i,
    output logic pulse_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din_i};
            prev_q <= sync_q[1];
        end
    end

    assign pulse_o = sync_q[1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/chip_test_sequencer.sv
// =============================================================================
// Module   : chip_test_sequencer
// Purpose  : Launches one checker on Start, waits for Done or timeout, releases
//            it and holds the verdict until Ack. Define STATS_EN for counters.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module chip_test_sequencer
    import chip_seq_pkg::*;
#(
    parameter int NUM_CHIPS      = 8,
    parameter int SEL_W          = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Ack,
    input  logic [SEL_W-1:0]     Chip_Sel,
    input  logic [NUM_CHIPS-1:0] Done_Vec,
    input  logic [NUM_CHIPS-1:0] RSLT_Vec,
    output logic [NUM_CHIPS-1:0] Run_Vec,
    output logic                 DISP_RSLT,
    output logic                 Busy,
    output logic [SEL_W-1:0]     Sel_Latched,
    output logic                 Pass,
    output logic                 Fail,
`ifdef STATS_EN
    output logic                 Timeout,
    output logic [STATS_W-1:0]   Pass_Cnt,
    output logic [STATS_W-1:0]   Fail_Cnt
`else
    output logic                 Timeout
`endif
);

    localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [31:0]       C_NUM    = NUM_CHIPS;

    logic [1:0]           rst_sync_q;
    logic                 w_rst_n;
    logic                 w_start_evt;
    logic                 w_ack_evt;
    logic                 w_sel_ok;
    logic [NUM_CHIPS-1:0] w_launch_vec;
    logic [NUM_CHIPS-1:0] w_sel_vec;
    logic                 w_done_sel;
    logic                 w_rslt_sel;

    seq_state_t           state_q;
    verdict_t             verdict_q;
    logic [SEL_W-1:0]     sel_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 to_q;
    logic                 res_q;
    logic [NUM_CHIPS-1:0] run_q;
    logic                 disp_q;

    // Assertion is immediate; release is aligned to Clk.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign w_rst_n = rst_sync_q[1];

    sync_edge_det u_start_det (
        .Clk     (Clk),
        .Reset_n (w_rst_n),
        .din_i   (Start),
        .pulse_o (w_start_evt)
    );

    sync_edge_det u_ack_det (
        .Clk     (Clk),
        .Reset_n (w_rst_n),
        .din_i   (Ack),
        .pulse_o (w_ack_evt)
    );

    assign w_sel_ok     = (32'(Chip_Sel) < C_NUM);
    assign w_launch_vec = NUM_CHIPS'(1) << Chip_Sel;
    assign w_sel_vec    = NUM_CHIPS'(1) << sel_q;
    assign w_done_sel   = |(Done_Vec & w_sel_vec);
    assign w_rslt_sel   = |(RSLT_Vec & w_sel_vec);

    always_ff @(posedge Clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q   <= IDLE;
            verdict_q <= V_NONE;
            sel_q     <= '0;
            cnt_q     <= '0;
            to_q      <= 1'b0;
            res_q     <= 1'b0;
            run_q     <= '0;
            disp_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_start_evt && w_sel_ok) begin
                        sel_q   <= Chip_Sel;
                        cnt_q   <= '0;
                        to_q    <= 1'b0;
                        res_q   <= 1'b0;
                        run_q   <= w_launch_vec;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    run_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Done on the last allowed cycle still counts as a real finish.
                    if (w_done_sel) begin
                        state_q <= CAPTURE;
                    end else if (cnt_q == CNT_LAST) begin
                        to_q    <= 1'b1;
                        disp_q  <= 1'b1;
                        state_q <= RELEASE;
                    end
                end
                CAPTURE: begin
                    res_q   <= w_rslt_sel;
                    disp_q  <= 1'b1;
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    disp_q    <= 1'b0;
                    verdict_q <= verdict_of(res_q, to_q);
                    state_q   <= SHOW;
                end
                SHOW: begin
                    if (w_ack_evt) begin
                        verdict_q <= V_NONE;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    run_q   <= '0;
                    disp_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Run_Vec     = run_q;
    assign DISP_RSLT   = disp_q;
    assign Sel_Latched = sel_q;
    assign Busy        = (state_q == LAUNCH) || (state_q == WAIT) ||
                         (state_q == CAPTURE) || (state_q == RELEASE);
    assign Pass        = (verdict_q == V_PASS);
    assign Fail        = (verdict_q == V_FAIL);
    assign Timeout     = (verdict_q == V_TIMEOUT);

`ifdef STATS_EN
    logic [STATS_W-1:0] pass_cnt_q;
    logic [STATS_W-1:0] fail_cnt_q;

    always_ff @(posedge Clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else if (state_q == RELEASE) begin
            if (res_q && !to_q) begin
                if (pass_cnt_q != '1) begin
                    pass_cnt_q <= pass_cnt_q + 1'b1;
                end
            end else if (fail_cnt_q != '1) begin
                fail_cnt_q <= fail_cnt_q + 1'b1;
            end
        end
    end

    assign Pass_Cnt = pass_cnt_q;
    assign Fail_Cnt = fail_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_chip_test_sequencer.sv
// =============================================================================
// Module   : tb_chip_test_sequencer
// Purpose  : Self-checking bench for chip_test_sequencer (long and short timeout).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_chip_test_sequencer;

    localparam int TO1 = 4096;
    localparam int TO2 = 16;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    logic       Start = 1'b0, Ack = 1'b0;
    logic [3:0] Chip_Sel = '0;
    logic [7:0] Done_Vec = '0, RSLT_Vec = '0;
    logic [7:0] Run_Vec;
    logic       DISP_RSLT, Busy, Pass, Fail, Timeout;
    logic [3:0] Sel_Latched;

    logic       Start2 = 1'b0, Ack2 = 1'b0;
    logic [2:0] Chip_Sel2 = '0;
    logic [7:0] Done_Vec2 = '0, RSLT_Vec2 = '0;
    logic [7:0] Run_Vec2;
    logic       DISP_RSLT2, Busy2, Pass2, Fail2, Timeout2;
    logic [2:0] Sel_Latched2;
`ifdef STATS_EN
    logic [7:0] Pass_Cnt, Fail_Cnt, Pass_Cnt2, Fail_Cnt2;
`endif

    chip_test_sequencer #(.NUM_CHIPS(8), .SEL_W(4), .TIMEOUT_CYCLES(TO1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack), .Chip_Sel(Chip_Sel),
        .Done_Vec(Done_Vec), .RSLT_Vec(RSLT_Vec), .Run_Vec(Run_Vec), .DISP_RSLT(DISP_RSLT),
        .Busy(Busy), .Sel_Latched(Sel_Latched), .Pass(Pass), .Fail(Fail),
`ifdef STATS_EN
        .Pass_Cnt(Pass_Cnt), .Fail_Cnt(Fail_Cnt),
`endif
        .Timeout(Timeout)
    );

    chip_test_sequencer #(.NUM_CHIPS(8), .SEL_W(3), .TIMEOUT_CYCLES(TO2)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start2), .Ack(Ack2), .Chip_Sel(Chip_Sel2),
        .Done_Vec(Done_Vec2), .RSLT_Vec(RSLT_Vec2), .Run_Vec(Run_Vec2), .DISP_RSLT(DISP_RSLT2),
        .Busy(Busy2), .Sel_Latched(Sel_Latched2), .Pass(Pass2), .Fail(Fail2),
`ifdef STATS_EN
        .Pass_Cnt(Pass_Cnt2), .Fail_Cnt(Fail_Cnt2),
`endif
        .Timeout(Timeout2)
    );

    bit         use2 = 1'b0;
    logic [7:0] m_run;
    logic       m_disp, m_busy, m_pass, m_fail, m_to;
    logic [3:0] m_sel;
    assign m_run  = use2 ? Run_Vec2   : Run_Vec;
    assign m_disp = use2 ? DISP_RSLT2 : DISP_RSLT;
    assign m_busy = use2 ? Busy2      : Busy;
    assign m_pass = use2 ? Pass2      : Pass;
    assign m_fail = use2 ? Fail2      : Fail;
    assign m_to   = use2 ? Timeout2   : Timeout;
    assign m_sel  = use2 ? {1'b0, Sel_Latched2} : Sel_Latched;
`ifdef STATS_EN
    logic [7:0] m_pcnt, m_fcnt;
    assign m_pcnt = use2 ? Pass_Cnt2 : Pass_Cnt;
    assign m_fcnt = use2 ? Fail_Cnt2 : Fail_Cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_p[2] = '{0, 0};
    int exp_f[2] = '{0, 0};
    int last_sel = 0;

    typedef struct {
        int         run_cnt, run_at, disp_cnt, disp_at, show_at;
        logic [7:0] run_val;
        logic       pass, fail, to;
    } obs_t;

    // Presses Start at relative cycle 0 and plays a checker that raises Done d
    // cycles after its Run pulse (d == 0: never), while other chips emit noise.
    task automatic run_dut(input int sel, input int d, input bit r, input int hold, output obs_t o);
        logic [7:0] m, dv, rv;
        bit dn;
        o.run_cnt = 0; o.run_at = -1; o.disp_cnt = 0; o.disp_at = -1; o.show_at = -1;
        o.run_val = '0; o.pass = 0; o.fail = 0; o.to = 0;
        m = 8'h01 << sel;
        if (use2) Chip_Sel2 = 3'(sel); else Chip_Sel = 4'(sel);
        for (int c = 0; c < 6000; c++) begin
            @(negedge Clk);
            if (m_run != 8'h00) begin o.run_cnt++; o.run_at = c; o.run_val = m_run; end
            if (m_disp) begin o.disp_cnt++; o.disp_at = c; end
            if (o.show_at < 0 && (m_pass || m_fail || m_to)) begin
                o.show_at = c; o.pass = m_pass; o.fail = m_fail; o.to = m_to;
            end
            if (o.show_at >= 0 && c >= hold && c >= o.show_at + 3) break;
            dn = (o.run_at >= 0) && (d > 0) && (c >= o.run_at + d) && (o.disp_at < 0);
            dv = (8'($urandom()) & ~m) | (dn ? m : 8'h00);
            rv = (8'($urandom()) & ~m) | (dn ? (r ? m : 8'h00) : (8'($urandom()) & m));
            if (use2) begin
                Start2 = (c < hold); Done_Vec2 = dv; RSLT_Vec2 = rv;
                if (c > 3) Chip_Sel2 = 3'($urandom());
            end else begin
                Start = (c < hold); Done_Vec = dv; RSLT_Vec = rv;
                if (c > 3) Chip_Sel = 4'($urandom());
            end
        end
        Start = 0; Start2 = 0;
        Done_Vec = '0; Done_Vec2 = '0; RSLT_Vec = '0; RSLT_Vec2 = '0;
    endtask

    task automatic test_single_run(input string tag, input int sel, input int d, input bit r, input int hold);
        obs_t o;
        int   t, e_disp;
        bit   done_ok, e_pass, e_fail, e_to;
        t       = use2 ? TO2 : TO1;
        done_ok = (d >= 1) && (d <= t);
        e_disp  = done_ok ? 3 + d + 2 : 3 + t + 1;
        e_pass  = done_ok && r;
        e_fail  = done_ok && !r;
        e_to    = !done_ok;
        run_dut(sel, d, r, hold, o);
        if (e_pass) begin if (exp_p[use2] < 255) exp_p[use2]++; end
        else if (exp_f[use2] < 255) exp_f[use2]++;
        if (!use2) last_sel = sel;

        n_checks++; if (o.run_at !== 3) begin n_fail++; $display("FAIL %s run_latency: got %0d expected 3", tag, o.run_at); end
        n_checks++; if (o.run_cnt !== 1) begin n_fail++; $display("FAIL %s run_pulses: got %0d expected 1", tag, o.run_cnt); end
        n_checks++; if (o.run_val !== (8'h01 << sel)) begin n_fail++; $display("FAIL %s run_vec: got %h expected %h", tag, o.run_val, 8'h01 << sel); end
        n_checks++; if (o.disp_cnt !== 1) begin n_fail++; $display("FAIL %s disp_pulses: got %0d expected 1", tag, o.disp_cnt); end
        n_checks++; if (o.disp_at !== e_disp) begin n_fail++; $display("FAIL %s disp_cycle: got %0d expected %0d", tag, o.disp_at, e_disp); end
        n_checks++; if (o.show_at !== e_disp + 1) begin n_fail++; $display("FAIL %s show_cycle: got %0d expected %0d", tag, o.show_at, e_disp + 1); end
        n_checks++; if ({o.pass, o.fail, o.to} !== {e_pass, e_fail, e_to}) begin
            n_fail++; $display("FAIL %s verdict pass/fail/to: got %b%b%b expected %b%b%b", tag, o.pass, o.fail, o.to, e_pass, e_fail, e_to); end
        n_checks++; if (m_sel !== 4'(sel)) begin n_fail++; $display("FAIL %s sel_latched: got %0d expected %0d", tag, m_sel, sel); end
        n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_in_show: got %b expected 0", tag, m_busy); end
`ifdef STATS_EN
        n_checks++; if (m_pcnt !== 8'(exp_p[use2]) || m_fcnt !== 8'(exp_f[use2])) begin
            n_fail++; $display("FAIL %s stats: got %0d/%0d expected %0d/%0d", tag, m_pcnt, m_fcnt, exp_p[use2], exp_f[use2]); end
`endif
        // Ack: verdict survives until the third edge after the press.
        @(negedge Clk); if (use2) Ack2 = 1; else Ack = 1;
        @(negedge Clk);
        @(negedge Clk);
        n_checks++; if ({m_pass, m_fail, m_to} !== {e_pass, e_fail, e_to}) begin
            n_fail++; $display("FAIL %s verdict_before_ack: got %b%b%b expected %b%b%b", tag, m_pass, m_fail, m_to, e_pass, e_fail, e_to); end
        Ack = 0; Ack2 = 0;
        @(negedge Clk);
        n_checks++; if ({m_pass, m_fail, m_to, m_busy, m_disp} !== 5'b0) begin
            n_fail++; $display("FAIL %s cleared_after_ack: got %b%b%b%b%b expected 00000", tag, m_pass, m_fail, m_to, m_busy, m_disp); end
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        n_checks++; if ({Run_Vec, DISP_RSLT, Busy, Sel_Latched, Pass, Fail, Timeout} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h/%b/%b/%h/%b%b%b expected all 0", Run_Vec, DISP_RSLT, Busy, Sel_Latched, Pass, Fail, Timeout); end
        n_checks++; if ({Run_Vec2, DISP_RSLT2, Busy2, Sel_Latched2, Pass2, Fail2, Timeout2} !== '0) begin
            n_fail++; $display("FAIL reset_outputs2: got %h/%b/%b/%h/%b%b%b expected all 0", Run_Vec2, DISP_RSLT2, Busy2, Sel_Latched2, Pass2, Fail2, Timeout2); end
        Reset_n = 1;
        repeat (4) @(negedge Clk);
        n_checks++; if ({Run_Vec, Busy, Pass, Fail, Timeout} !== '0) begin
            n_fail++; $display("FAIL after_reset_idle: got %h/%b/%b%b%b expected all 0", Run_Vec, Busy, Pass, Fail, Timeout); end
    endtask

    task automatic test_out_of_range();
        int runs, busys;
        for (int s = 8; s <= 9; s++) begin
            runs = 0; busys = 0;
            Chip_Sel = 4'(s);
            for (int c = 0; c < 12; c++) begin
                @(negedge Clk);
                if (Run_Vec != 8'h00) runs++;
                if (Busy) busys++;
                Start = (c < 4);
            end
            n_checks++; if (runs !== 0 || busys !== 0) begin
                n_fail++; $display("FAIL out_of_range sel=%0d: got runs=%0d busy=%0d expected 0/0", s, runs, busys); end
            n_checks++; if (Sel_Latched !== 4'(last_sel)) begin
                n_fail++; $display("FAIL out_of_range_sel_latched sel=%0d: got %0d expected %0d", s, Sel_Latched, last_sel); end
        end
        Start = 0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_hold_start();
        obs_t o;
        int   d, runs, busys;
        bit   e_pass;
        d = $urandom_range(5, 40);
        e_pass = 1'b1;
        use2 = 0;
        run_dut(3, d, e_pass, 500, o);
        last_sel = 3;
        if (exp_p[0] < 255) exp_p[0]++;
        n_checks++; if (o.run_cnt !== 1 || o.disp_cnt !== 1) begin
            n_fail++; $display("FAIL hold_start pulses: got run=%0d disp=%0d expected 1/1", o.run_cnt, o.disp_cnt); end
        n_checks++; if (o.pass !== 1'b1 || o.show_at !== 3 + d + 3) begin
            n_fail++; $display("FAIL hold_start verdict: got pass=%b at %0d expected 1 at %0d", o.pass, o.show_at, 3 + d + 3); end
        runs = 0; busys = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            if (Run_Vec != 8'h00) runs++;
            if (Busy) busys++;
            Start = (c < 3);
        end
        n_checks++; if (runs !== 0 || busys !== 0 || Pass !== 1'b1) begin
            n_fail++; $display("FAIL start_in_show: got runs=%0d busy=%0d pass=%b expected 0/0/1", runs, busys, Pass); end
        runs = 0; busys = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge Clk);
            if (Run_Vec != 8'h00) runs++;
            if (Busy) busys++;
            Start = (c < 3); Ack = (c < 3);
        end
        n_checks++; if (runs !== 0 || busys !== 0 || {Pass, Fail, Timeout} !== 3'b000) begin
            n_fail++; $display("FAIL start_and_ack: got runs=%0d busy=%0d verdict=%b%b%b expected 0/0/000", runs, busys, Pass, Fail, Timeout); end
`ifdef STATS_EN
        n_checks++; if (Pass_Cnt !== 8'(exp_p[0])) begin
            n_fail++; $display("FAIL hold_start stats: got %0d expected %0d", Pass_Cnt, exp_p[0]); end
`endif
        Start = 0; Ack = 0;
    endtask

    task automatic test_reset_mid_wait();
        use2 = 0;
        Chip_Sel = 4'd4;
        @(negedge Clk); Start = 1;
        repeat (3) @(negedge Clk);
        n_checks++; if (Run_Vec !== 8'h10) begin n_fail++; $display("FAIL launch_before_reset: got %h expected 10", Run_Vec); end
        #2 Reset_n = 0;
        #1;
        n_checks++; if (Run_Vec !== 8'h00 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_launch: got run=%h busy=%b expected 00/0", Run_Vec, Busy); end
        Start = 0;
        @(negedge Clk); Reset_n = 1;
        repeat (4) @(negedge Clk);
        Start = 1;
        repeat (10) @(negedge Clk);
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_wait: got %b expected 1", Busy); end
        #2 Reset_n = 0;
        #1;
        n_checks++; if ({Run_Vec, DISP_RSLT, Busy, Sel_Latched, Pass, Fail, Timeout} !== '0) begin
            n_fail++; $display("FAIL reset_in_wait: got %h/%b/%b/%h/%b%b%b expected all 0", Run_Vec, DISP_RSLT, Busy, Sel_Latched, Pass, Fail, Timeout); end
        Start = 0;
        @(negedge Clk); Reset_n = 1;
        exp_p = '{0, 0}; exp_f = '{0, 0}; last_sel = 0;
        repeat (4) @(negedge Clk);
        test_single_run("after_reset", 6, 7, 1'b1, 2);
    endtask

    initial begin
        test_reset();
        use2 = 0; test_single_run("T1_pass", 2, 1024, 1'b1, 3);
        use2 = 0; test_single_run("T2_fail", 2, 1024, 1'b0, 3);
        use2 = 1; test_single_run("T3_timeout", 5, 0, 1'b1, 2);
        use2 = 1; test_single_run("done_at_limit", 1, TO2, 1'b1, 2);
        use2 = 1; test_single_run("done_past_limit", 0, TO2 + 1, 1'b1, 2);
        use2 = 0; test_single_run("max_sel", 7, 1, 1'b0, 1);
        test_out_of_range();
        test_hold_start();
        for (int i = 0; i < 10; i++) begin
            use2 = 1'($urandom());
            test_single_run($sformatf("random%0d", i), $urandom_range(0, 7), $urandom_range(1, 40),
                            1'($urandom()), $urandom_range(1, 20));
        end
        use2 = 0;
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
